// File: rtl/dot_seq_pkg.sv
// Shared types and width helpers for the time-multiplexed dot-product sequencer.
package dot_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MAC   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Length must be able to hold VECTOR_DIMENSION itself, not just the last index.
    function automatic int calc_len_w(input int vector_dimension);
        return $clog2(vector_dimension + 1);
    endfunction

    function automatic int calc_addr_w(input int vector_dimension);
        return (vector_dimension > 1) ? $clog2(vector_dimension) : 1;
    endfunction

endpackage

// File: rtl/fixed_pt_mac.sv
// Combinational fixed-point multiply (floor-shifted full product) plus wrapping accumulate.
module fixed_pt_mac #(
    parameter int ELEMENT_WIDTH = 64,
    parameter int DECIMAL_PLACE = 24
) (
    input  logic signed [ELEMENT_WIDTH-1:0] acc_in,
    input  logic signed [ELEMENT_WIDTH-1:0] a,
    input  logic signed [ELEMENT_WIDTH-1:0] b,
    output logic signed [ELEMENT_WIDTH-1:0] acc_out
);

    logic signed [2*ELEMENT_WIDTH-1:0] prod;
    logic signed [ELEMENT_WIDTH-1:0]   fmul;

    assign prod = a * b;
    // Arithmetic shift floors toward -inf; upper product bits are dropped on purpose.
    assign fmul    = ELEMENT_WIDTH'(prod >>> DECIMAL_PLACE);
    assign acc_out = acc_in + fmul;

endmodule

// File: rtl/dot_product_sequencer.sv
// Dot-product engine: one shared fixed-point MAC, one element pair fetched per iteration.
module dot_product_sequencer
    import dot_seq_pkg::*;
#(
    parameter int ELEMENT_WIDTH    = 64,
    parameter int DECIMAL_PLACE    = 24,
    parameter int VECTOR_DIMENSION = 10,
    localparam int LEN_W  = calc_len_w(VECTOR_DIMENSION),
    localparam int ADDR_W = calc_addr_w(VECTOR_DIMENSION)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start_valid,
    output logic                            start_ready,
    input  logic [LEN_W-1:0]                start_length,
    output logic                            elem_req,
    output logic [ADDR_W-1:0]               elem_addr,
    input  logic                            elem_valid,
    input  logic signed [ELEMENT_WIDTH-1:0] vec0_data,
    input  logic signed [ELEMENT_WIDTH-1:0] vec1_data,
    output logic                            result_valid,
    input  logic                            result_ready,
    output logic signed [ELEMENT_WIDTH-1:0] result,
    output logic                            busy
);

    // Handshakes: a transfer happens on a rising clk edge where valid & ready are both high;
    // the producer holds valid and its payload stable until that edge, ready never gates valid.

    state_t                     state, state_next;
    logic [LEN_W-1:0]           len;
    logic [ADDR_W-1:0]          idx;
    logic signed [ELEMENT_WIDTH-1:0] acc, op_a, op_b, mac_out;
    logic [LEN_W-1:0]           len_clamped;
    logic                       start_fire;
    logic                       last;

    assign start_fire  = start_valid && (state == IDLE);
    assign len_clamped = (start_length > LEN_W'(VECTOR_DIMENSION)) ?
                         LEN_W'(VECTOR_DIMENSION) : start_length;
    assign last        = (LEN_W'(idx) == (len - LEN_W'(1)));

    fixed_pt_mac #(
        .ELEMENT_WIDTH (ELEMENT_WIDTH),
        .DECIMAL_PLACE (DECIMAL_PLACE)
    ) u_mac (
        .acc_in  (acc),
        .a       (op_a),
        .b       (op_b),
        .acc_out (mac_out)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_fire) state_next = (len_clamped != '0) ? FETCH : DONE;
            FETCH:   if (elem_valid) state_next = MAC;
            MAC:     state_next = last ? DONE : FETCH;
            DONE:    if (result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers; reset also discards any partial sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            len  <= '0;
            idx  <= '0;
            acc  <= '0;
            op_a <= '0;
            op_b <= '0;
        end else begin
            case (state)
                IDLE: if (start_fire) begin
                    len <= len_clamped;
                    idx <= '0;
                    acc <= '0;
                end
                FETCH: if (elem_valid) begin
                    op_a <= vec0_data;
                    op_b <= vec1_data;
                end
                MAC: begin
                    acc <= mac_out;
                    if (!last) idx <= idx + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign start_ready  = (state == IDLE);
    assign busy         = (state != IDLE);
    assign elem_req     = (state == FETCH);
    assign elem_addr    = idx;
    assign result_valid = (state == DONE);
    assign result       = acc;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer: memory responder, command driver, result scoreboard.
module tb_dot_product_sequencer;
    import dot_seq_pkg::*;

    localparam int W      = 64;
    localparam int VD     = 10;
    localparam int LEN_W  = calc_len_w(VD);
    localparam int ADDR_W = calc_addr_w(VD);
    localparam logic [W-1:0] ONE = 64'h0000_0000_0100_0000;

    logic              clk;
    logic              reset;
    logic              start_valid;
    logic              start_ready;
    logic [LEN_W-1:0]  start_length;
    logic              elem_req;
    logic [ADDR_W-1:0] elem_addr;
    logic              elem_valid;
    logic [W-1:0]      vec0_data;
    logic [W-1:0]      vec1_data;
    logic              result_valid;
    logic              result_ready;
    logic [W-1:0]      result;
    logic              busy;

    dot_product_sequencer #(
        .ELEMENT_WIDTH    (W),
        .DECIMAL_PLACE    (24),
        .VECTOR_DIMENSION (VD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .start_length (start_length),
        .elem_req     (elem_req),
        .elem_addr    (elem_addr),
        .elem_valid   (elem_valid),
        .vec0_data    (vec0_data),
        .vec1_data    (vec1_data),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .busy         (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- shared state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int           exp_lat_q[$];
    int           addr_exp_q[$];
    logic [W-1:0] mem0 [0:VD-1];
    logic [W-1:0] mem1 [0:VD-1];
    int stall_cycles = 0;
    int rr_delay     = 0;
    int fire_ref     = 0;
    int accept_cyc   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event expected normal progress (cycle %0d)", name, cyc);
    endtask

    // ---------------- element memory responder ----------------
    int stall_cnt = 0;
    always @(negedge clk) begin
        if (reset || !elem_req) begin
            elem_valid = 1'b0;
            stall_cnt  = 0;
        end else if (addr_exp_q.size() == 0) begin
            fail_now("unexpected_fetch");
            elem_valid = 1'b0;
        end else if (stall_cnt < stall_cycles) begin
            check("addr_stable", W'(elem_addr), W'(addr_exp_q[0]));
            elem_valid = 1'b0;
            stall_cnt++;
        end else begin
            check("elem_addr", W'(elem_addr), W'(addr_exp_q.pop_front()));
            elem_valid = 1'b1;
            vec0_data  = mem0[elem_addr];
            vec1_data  = mem1[elem_addr];
            stall_cnt  = 0;
        end
    end

    // ---------------- result monitor / scoreboard ----------------
    logic prev_valid = 1'b0;
    int   hold_cnt   = 0;
    always @(negedge clk) begin
        if (reset) begin
            result_ready = 1'b0;
            prev_valid   = 1'b0;
            hold_cnt     = 0;
        end else begin
            if (result_valid) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_result");
                    result_ready = 1'b1;
                end else begin
                    if (!prev_valid) begin
                        if (exp_lat_q.size() == 0) fail_now("unexpected_latency_entry");
                        else check("latency", W'(cyc - fire_ref), W'(exp_lat_q.pop_front()));
                    end else begin
                        check("held_result", result, exp_q[0]);
                        check("start_ready_in_done", W'(start_ready), W'(0));
                        check("busy_in_done", W'(busy), W'(1));
                    end
                    if (hold_cnt < rr_delay) begin
                        result_ready = 1'b0;
                        hold_cnt++;
                    end else begin
                        result_ready = 1'b1;
                        check("result", result, exp_q.pop_front());
                        accept_cyc = cyc;
                        hold_cnt   = 0;
                    end
                end
            end else begin
                result_ready = 1'b0;
                hold_cnt     = 0;
            end
            prev_valid = result_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_mem(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        mem0[i] = a;
        mem1[i] = b;
    endtask

    // Called at a negedge; returns at the negedge after the start fires.
    task automatic run_cmd(input int len, input logic [W-1:0] exp_res, input int exp_lat, input bit b2b);
        int n;
        int guard;
        n = (len > VD) ? VD : len;
        for (int i = 0; i < n; i++) addr_exp_q.push_back(i);
        exp_q.push_back(exp_res);
        exp_lat_q.push_back(exp_lat);
        start_valid  = 1'b1;
        start_length = len[LEN_W-1:0];
        guard = 0;
        while (!start_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (!start_ready) fail_now("start_timeout");
        if (b2b) check("b2b_start_cycle", W'(cyc), W'(accept_cyc + 1));
        fire_ref = cyc;
        @(posedge clk);
        #1;
        start_valid  = 1'b0;
        start_length = '0;
        @(negedge clk);
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0 || busy) fail_now("done_timeout");
    endtask

    task automatic load_len3();
        set_mem(0, ONE,              3 * ONE);
        set_mem(1, 2 * ONE,          ONE >> 1);
        set_mem(2, 64'hFFFF_FFFF_FF80_0000, 4 * ONE);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int guard;
        reset        = 1'b1;
        start_valid  = 1'b0;
        start_length = '0;
        elem_valid   = 1'b0;
        vec0_data    = '0;
        vec1_data    = '0;
        result_ready = 1'b0;
        for (int i = 0; i < VD; i++) set_mem(i, '0, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        check("rst_start_ready",  W'(start_ready),  W'(1));
        check("rst_elem_req",     W'(elem_req),     W'(0));
        check("rst_elem_addr",    W'(elem_addr),    W'(0));
        check("rst_result_valid", W'(result_valid), W'(0));
        check("rst_result",       result,           W'(0));
        check("rst_busy",         W'(busy),         W'(0));

        // Length-3: 1*3 + 2*0.5 + (-0.5)*4 = 2.0
        load_len3();
        run_cmd(3, 64'h0000_0000_0200_0000, 7, 1'b0);
        wait_done();

        // Empty command
        run_cmd(0, '0, 1, 1'b0);
        wait_done();

        // Length clamp to 10
        for (int i = 0; i < VD; i++) set_mem(i, ONE, ONE);
        run_cmd(15, 64'h0000_0000_0A00_0000, 21, 1'b0);
        wait_done();
        check("clamp_fetches_left", W'(addr_exp_q.size()), W'(0));

        // No-stall vs stall: 1*3 + 2*0.5 = 4.0
        set_mem(0, ONE,     3 * ONE);
        set_mem(1, 2 * ONE, ONE >> 1);
        run_cmd(2, 64'h0000_0000_0400_0000, 5, 1'b0);
        wait_done();
        stall_cycles = 3;
        run_cmd(2, 64'h0000_0000_0400_0000, 11, 1'b0);
        wait_done();
        stall_cycles = 0;

        // Result back-pressure, then back-to-back start
        rr_delay = 5;
        run_cmd(1, 64'h0000_0000_0300_0000, 3, 1'b0);
        run_cmd(2, 64'h0000_0000_0400_0000, 5, 1'b1);
        wait_done();
        rr_delay = 0;

        // Reset during a stalled FETCH of idx 1
        load_len3();
        stall_cycles = 3;
        run_cmd(3, '0, 0, 1'b0);
        guard = 0;
        while (!(elem_req && elem_addr == ADDR_W'(1)) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!(elem_req && elem_addr == ADDR_W'(1))) fail_now("wait_fetch1_timeout");
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_elem_req",     W'(elem_req),     W'(0));
        check("mid_rst_busy",         W'(busy),         W'(0));
        check("mid_rst_start_ready",  W'(start_ready),  W'(1));
        check("mid_rst_result_valid", W'(result_valid), W'(0));
        check("mid_rst_result",       result,           W'(0));
        reset = 1'b0;
        exp_q.delete();
        exp_lat_q.delete();
        addr_exp_q.delete();
        stall_cycles = 0;
        run_cmd(3, 64'h0000_0000_0200_0000, 7, 1'b0);
        wait_done();

        // Wrap: 2 * (0x7FFF...F * 1.0) mod 2^64
        set_mem(0, 64'h7FFF_FFFF_FFFF_FFFF, ONE);
        set_mem(1, 64'h7FFF_FFFF_FFFF_FFFF, ONE);
        run_cmd(2, 64'hFFFF_FFFF_FFFF_FFFE, 5, 1'b0);
        wait_done();

        check("final_results_left", W'(exp_q.size()),      W'(0));
        check("final_fetches_left", W'(addr_exp_q.size()), W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
